// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: holds the CPU in reset, releases it for a programmed run and
// compares the observed memory address against a preloaded expected trace.
// Outcome is reported through done/pass/fail_idx/cycle_count.
// Optional feature macro: CPU_MON_CAPTURE_EN adds a capture RAM that records
// the observed address of every RUN cycle, readable through cap_rd_idx/cap_rd_data.
//
// Strobe semantics: start and exp_wr_en are single-cycle, fire-and-forget
// strobes with no ready/acknowledge. A start is taken only in IDLE or DONE; an
// expected-RAM write is taken only in IDLE or DONE with an index below
// TRACE_DEPTH. Anything offered at other times is dropped silently, and rst
// overrides both in the same cycle.
module cpu_run_monitor #(
  parameter int ADDR_W      = 8,
  parameter int TRACE_DEPTH = 16,
  parameter int RST_CYCLES  = 1,
  localparam int IDX_W      = $clog2(TRACE_DEPTH),
  localparam int LEN_W      = $clog2(TRACE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  exp_len,
  input  logic              exp_wr_en,
  input  logic [IDX_W-1:0]  exp_wr_idx,
  input  logic [ADDR_W-1:0] exp_wr_addr,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [LEN_W-1:0]  cycle_count,
  input  logic [IDX_W-1:0]  cap_rd_idx,
  output logic [ADDR_W-1:0] cap_rd_data
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  // State is kept in a named enum so checkers can bind to state_q directly.
  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic [LEN_W-1:0]  cycle_count_q, cycle_count_d;

  logic [ADDR_W-1:0] exp_mem [TRACE_DEPTH];

  logic [IDX_W-1:0]  run_idx;
  logic [LEN_W-1:0]  len_clamped;
  logic              run_match;
  logic              run_last;
  logic              rc_last;
  logic              accepting;
  logic              wr_ok;

  // The number of cycles already compared is also the index of the entry
  // compared in the current RUN cycle.
  assign run_idx     = cycle_count_q[IDX_W-1:0];
  assign run_match   = (mem_addr == exp_mem[run_idx]);
  assign run_last    = ((cycle_count_q + LEN_W'(1)) == len_q);
  assign rc_last     = (rc_q == RC_W'(RST_CYCLES - 1));
  assign len_clamped = (exp_len > LEN_W'(TRACE_DEPTH)) ? LEN_W'(TRACE_DEPTH) : exp_len;
  assign accepting   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_ok       = exp_wr_en && !rst && accepting && (int'(exp_wr_idx) < TRACE_DEPTH);

  // State register plus registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rc_q          <= '0;
      len_q         <= '0;
      cpu_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_idx_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rc_q          <= rc_d;
      len_q         <= len_d;
      cpu_rst_q     <= cpu_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_idx_q    <= fail_idx_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Next-state logic: a zero-length run skips RUN entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RESET;
      S_RESET:        if (rc_last) state_d = (len_q == '0) ? S_DONE : S_RUN;
      S_RUN:          if (!run_match || run_last) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; result fields change on the edge done rises.
  always_comb begin
    rc_d          = rc_q;
    len_d         = len_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_idx_d    = fail_idx_q;
    cycle_count_d = cycle_count_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rc_d          = '0;
          len_d         = len_clamped;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_idx_d    = '0;
          cycle_count_d = '0;
        end
      end
      S_RESET: begin
        rc_d = rc_q + RC_W'(1);
        if (rc_last && (len_q == '0)) begin
          done_d = 1'b1;
          pass_d = 1'b1;
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + LEN_W'(1);
        if (!run_match) begin
          done_d     = 1'b1;
          pass_d     = 1'b0;
          fail_idx_d = run_idx;
        end else if (run_last) begin
          done_d = 1'b1;
          pass_d = 1'b1;
        end
      end
      default: ;
    endcase
    cpu_rst_d = (state_d != S_RUN);
    busy_d    = (state_d == S_RESET) || (state_d == S_RUN);
  end

  // Expected-trace RAM; deliberately not cleared by rst.
  always_ff @(posedge clk) begin
    if (wr_ok) exp_mem[exp_wr_idx] <= exp_wr_addr;
  end

`ifdef CPU_MON_CAPTURE_EN
  logic [ADDR_W-1:0] cap_mem [TRACE_DEPTH];

  // Capture every RUN cycle's address, including a mismatching one.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_RUN)) cap_mem[run_idx] <= mem_addr;
  end

  assign cap_rd_data = (int'(cap_rd_idx) < TRACE_DEPTH) ? cap_mem[cap_rd_idx] : '0;
`else
  logic unused_cap_rd_idx;
  assign unused_cap_rd_idx = ^cap_rd_idx;
  assign cap_rd_data       = '0;
`endif

  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_idx    = fail_idx_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a run-timeline model.
module tb_cpu_run_monitor;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;
  localparam int RC     = 1;
  localparam int IDX_W  = 4;
  localparam int LEN_W  = 5;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  exp_len = '0;
  logic              exp_wr_en = 1'b0;
  logic [IDX_W-1:0]  exp_wr_idx = '0;
  logic [ADDR_W-1:0] exp_wr_addr = '0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [IDX_W-1:0]  cap_rd_idx = '0;
  logic              cpu_rst, busy, done, pass;
  logic [IDX_W-1:0]  fail_idx;
  logic [LEN_W-1:0]  cycle_count;
  logic [ADDR_W-1:0] cap_rd_data;

  always #5 clk = ~clk;

  cpu_run_monitor #(.ADDR_W(ADDR_W), .TRACE_DEPTH(DEPTH), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_len(exp_len),
    .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx), .exp_wr_addr(exp_wr_addr),
    .mem_addr(mem_addr), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .pass(pass), .fail_idx(fail_idx), .cycle_count(cycle_count),
    .cap_rd_idx(cap_rd_idx), .cap_rd_data(cap_rd_data)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // A run is described by its start edge m_t0 and its number of compared
  // cycles m_n; every output follows from the edge distance t = cyc - m_t0.
  logic [ADDR_W-1:0] m_exp [DEPTH];
  logic [ADDR_W-1:0] m_cap [DEPTH];
  bit                m_cap_vld [DEPTH];
  logic [ADDR_W-1:0] plan [DEPTH];
  int  cyc = 0, m_t0 = 0, m_n = 0, m_fidx = 0;
  bit  m_has_run = 0, m_pass = 0;
  bit  e_cpu_rst = 1, e_busy = 0, e_done = 0, e_pass = 0;
  int  e_fidx = 0, e_cc = 0;
  bit  cmp_en = 0;

  always @(posedge clk) begin
    int tp, t, len;
    bit pre_busy, found;
    tp = cyc - m_t0;
    pre_busy = m_has_run && (tp < RC + m_n);
    if (!rst && m_has_run && tp >= RC && tp < RC + m_n) begin
      m_cap[tp - RC] = mem_addr;
      m_cap_vld[tp - RC] = 1'b1;
    end
    cyc = cyc + 1;
    if (rst) begin
      m_has_run = 1'b0;
    end else if (!pre_busy) begin
      if (exp_wr_en) m_exp[exp_wr_idx] = exp_wr_addr;
      if (start) begin
        len = (int'(exp_len) > DEPTH) ? DEPTH : int'(exp_len);
        m_n = len; m_pass = 1'b1; m_fidx = 0; found = 1'b0;
        for (int k = 0; k < len; k++) begin
          if (!found && plan[k] !== m_exp[k]) begin
            found = 1'b1; m_n = k + 1; m_pass = 1'b0; m_fidx = k;
          end
        end
        m_has_run = 1'b1;
        m_t0 = cyc;
      end
    end
    t = cyc - m_t0;
    if (!m_has_run) begin
      e_cpu_rst = 1; e_busy = 0; e_done = 0; e_pass = 0; e_fidx = 0; e_cc = 0;
    end else begin
      e_done    = (t >= RC + m_n);
      e_busy    = !e_done;
      e_cpu_rst = !(t >= RC && t < RC + m_n);
      e_cc      = (t < RC) ? 0 : ((t - RC > m_n) ? m_n : t - RC);
      e_pass    = e_done && m_pass;
      e_fidx    = e_done ? m_fidx : 0;
    end
  end

  // mem_addr follows the plan during the run's compare window, noise elsewhere.
  always @(negedge clk) begin
    int k;
    k = cyc - m_t0 - RC;
    if (m_has_run && k >= 0 && k < m_n) mem_addr = plan[k];
    else mem_addr = ADDR_W'($urandom);
  end

  // Compare process: every output, every cycle, once reset has been applied.
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("cpu_rst", 32'(cpu_rst), 32'(e_cpu_rst));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("pass", 32'(pass), 32'(e_pass));
      chk("fail_idx", 32'(fail_idx), 32'(e_fidx));
      chk("cycle_count", 32'(cycle_count), 32'(e_cc));
`ifdef CPU_MON_CAPTURE_EN
      if (m_cap_vld[cap_rd_idx]) chk("cap_rd_data", 32'(cap_rd_data), 32'(m_cap[cap_rd_idx]));
`else
      chk("cap_rd_data", 32'(cap_rd_data), 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut(input int n);
    @(negedge clk); rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample();
    @(posedge clk); #3;
  endtask

  task automatic write_exp(input int idx, input logic [ADDR_W-1:0] val);
    @(negedge clk);
    exp_wr_en = 1'b1; exp_wr_idx = IDX_W'(idx); exp_wr_addr = val;
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk); exp_len = LEN_W'(len); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Start a run and sample until done; reports edges from the start edge and
  // the number of samples with cpu_rst low.
  task automatic run_len(input int len, input int budget, output int edges, output int low);
    bit tmo;
    @(negedge clk); exp_len = LEN_W'(len); start = 1'b1;
    edges = 0; low = 0; tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (tmo) begin
        sample();
        start = 1'b0;
        edges++;
        if (!cpu_rst) low++;
        if (done) tmo = 1'b0;
      end
    end
    chk("run_timeout", 32'(tmo), 32'd0);
  endtask

  task automatic wait_run(input int budget);
    bit tmo;
    tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (tmo) begin
        sample();
        if (!cpu_rst) tmo = 1'b0;
      end
    end
    chk("run_entry_timeout", 32'(tmo), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    bit tmo;
    tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (tmo) begin
        sample();
        if (done) tmo = 1'b0;
      end
    end
    chk("done_timeout", 32'(tmo), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges, low, mi;
    bit mm;
    for (int k = 0; k < DEPTH; k++) plan[k] = ADDR_W'(k);

    // Reset release and idle hold
    reset_dut(2);
    cmp_en = 1'b1;
    sample();
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (3) sample();
    chk("idle_hold_busy", 32'(busy), 32'd0);
    chk("idle_hold_cpu_rst", 32'(cpu_rst), 32'd1);

    // Load trace 0..5, rest random
    for (int i = 0; i < DEPTH; i++) write_exp(i, (i < 6) ? ADDR_W'(i) : ADDR_W'($urandom));
    @(negedge clk); exp_wr_en = 1'b0;

    // Passing run
    run_len(6, 40, edges, low);
    chk("pass_low_cycles", 32'(low), 32'd6);
    chk("pass_pass", 32'(pass), 32'd1);
    chk("pass_cycle_count", 32'(cycle_count), 32'd6);
    chk("pass_fail_idx", 32'(fail_idx), 32'd0);

    // Mismatch at RUN cycle 3
    plan[3] = 8'h09;
    run_len(6, 40, edges, low);
    chk("mm_pass", 32'(pass), 32'd0);
    chk("mm_fail_idx", 32'(fail_idx), 32'd3);
    chk("mm_cycle_count", 32'(cycle_count), 32'd4);
    chk("mm_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mm_low_cycles", 32'(low), 32'd4);
    @(negedge clk); cap_rd_idx = 4'd3;
    sample();
`ifdef CPU_MON_CAPTURE_EN
    chk("cap_idx3", 32'(cap_rd_data), 32'h09);
`else
    chk("cap_idx3", 32'(cap_rd_data), 32'h00);
`endif
    @(negedge clk); cap_rd_idx = 4'd1;
    sample();
`ifdef CPU_MON_CAPTURE_EN
    chk("cap_idx1", 32'(cap_rd_data), 32'h01);
`else
    chk("cap_idx1", 32'(cap_rd_data), 32'h00);
`endif
    plan[3] = 8'h03;

    // Zero length: done after RC+1 edges with no RUN cycle
    run_len(0, 20, edges, low);
    chk("len0_edges", 32'(edges), 32'(RC + 1));
    chk("len0_low_cycles", 32'(low), 32'd0);
    chk("len0_pass", 32'(pass), 32'd1);
    chk("len0_cycle_count", 32'(cycle_count), 32'd0);

    // Length 31 clamps to 16 compares
    for (int k = 0; k < DEPTH; k++) plan[k] = m_exp[k];
    run_len(31, 60, edges, low);
    chk("clamp_cycle_count", 32'(cycle_count), 32'd16);
    chk("clamp_pass", 32'(pass), 32'd1);
    chk("clamp_low_cycles", 32'(low), 32'd16);

    // start and a RAM write during RUN are both ignored
    pulse_start(6);
    wait_run(20);
    @(negedge clk);
    start = 1'b1; exp_wr_en = 1'b1; exp_wr_idx = 4'd2; exp_wr_addr = 8'hAA;
    @(negedge clk);
    start = 1'b0; exp_wr_en = 1'b0;
    wait_done(40);
    chk("intf_pass", 32'(pass), 32'd1);
    chk("intf_cycle_count", 32'(cycle_count), 32'd6);
    run_len(6, 40, edges, low);
    chk("intf_rerun_pass", 32'(pass), 32'd1);

    // rst during RUN cycle 2
    pulse_start(6);
    wait_run(20);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    sample();
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    @(negedge clk); rst = 1'b0;
    run_len(6, 40, edges, low);
    chk("midrst_rerun_pass", 32'(pass), 32'd1);
    chk("midrst_rerun_cc", 32'(cycle_count), 32'd6);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 199) == 0);
      exp_wr_en   = ($urandom_range(0, 2) == 0);
      exp_wr_idx  = IDX_W'($urandom);
      exp_wr_addr = ADDR_W'($urandom);
      cap_rd_idx  = IDX_W'($urandom);
      start       = ($urandom_range(0, 5) == 0);
      exp_len     = LEN_W'($urandom_range(0, 31));
      if (start && !e_busy) begin
        mm = 1'($urandom_range(0, 1));
        mi = $urandom_range(0, DEPTH - 1);
        for (int k = 0; k < DEPTH; k++) plan[k] = m_exp[k];
        if (mm) plan[mi] = m_exp[mi] ^ ADDR_W'($urandom_range(1, 255));
      end
    end
    @(negedge clk);
    rst = 1'b0; exp_wr_en = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
